// File: rtl/btn_pkg.sv
`default_nettype none
//==============================================================================
// Module      : btn_pkg
// Description : Shared definitions for the button step generator: main FSM
//               state encoding, default timing constants and a counter-width
//               helper. The REPEAT state exists only when BTN_AUTOREPEAT_EN
//               is defined.
// Revision    : 1.0 - initial release
//==============================================================================
package btn_pkg;

    // Default timing, in CLK cycles
    localparam int c_DEB_CYCLES = 1000000;
    localparam int c_REP_DELAY  = 50000000;
    localparam int c_REP_PERIOD = 15000000;

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        REPEAT  = 2'd2,
        LOCKOUT = 2'd3
    } btn_state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        LOCKOUT = 2'd3
    } btn_state_t;
`endif

    // Width of a counter that must reach n-1; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_step_gen_if.sv
`default_nettype none
//==============================================================================
// Module      : btn_step_gen_if
// Description : Button / strobe bundle between the panel and the field
//               registers.
//               BTN_UP, BTN_DOWN : raw asynchronous buttons, active-high
//               EN               : edit-mode enable
//               UP, DOWN         : single-cycle step strobes
//               master : panel/field-register side; slave : generator side.
// Revision    : 1.0 - initial release
//==============================================================================
interface btn_step_gen_if;
    logic BTN_UP;
    logic BTN_DOWN;
    logic EN;
    logic UP;
    logic DOWN;

    modport master (
        output BTN_UP,
        output BTN_DOWN,
        output EN,
        input  UP,
        input  DOWN
    );

    modport slave (
        input  BTN_UP,
        input  BTN_DOWN,
        input  EN,
        output UP,
        output DOWN
    );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
//==============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer followed by a debouncer. The accepted
//               level follows the synchronized input only after it has
//               differed for DEB_CYCLES consecutive cycles; any return to the
//               accepted level restarts the count.
// Ports       : CLK      - clock, rising edge
//               RST      - asynchronous active-high reset
//               i_btn    - raw asynchronous button
//               o_level  - accepted (debounced) level
//               o_rise   - one-cycle pulse in the first cycle o_level is high
// Revision    : 1.0 - initial release
//==============================================================================
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = c_DEB_CYCLES
) (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic i_btn,
    output logic      o_level,
    output logic      o_rise
);

    localparam int              c_CW      = cnt_width(DEB_CYCLES);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_rise;
    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                // DEB_CYCLES-th consecutive differing sample: accept it.
                // The counter never passes c_CNT_MAX, so it cannot wrap.
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/btn_step_gen.sv
`default_nettype none
//==============================================================================
// Module      : btn_step_gen
// Description : Converts two raw push-buttons into single-cycle UP / DOWN
//               step strobes for the field registers. Each button is
//               synchronized and debounced, then a four-state FSM
//               (IDLE, DELAY, REPEAT, LOCKOUT) issues one strobe per press
//               and, optionally, auto-repeat strobes while the button is held.
//               Pressing both buttons locks out all strobes until both are
//               released.
// Ports       : CLK    - clock, rising edge
//               RST    - asynchronous active-high reset
//               btn_if - slave side of btn_step_gen_if
//                        (BTN_UP, BTN_DOWN, EN in; UP, DOWN out)
// Config      : BTN_AUTOREPEAT_EN - when defined, a held button produces a
//               strobe REP_DELAY cycles after the first one and then every
//               REP_PERIOD cycles. When undefined, the REPEAT state and the
//               repeat counters are absent: one strobe per press.
// Revision    : 1.0 - initial release
//==============================================================================
module btn_step_gen
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = c_DEB_CYCLES,
    parameter int REP_DELAY  = c_REP_DELAY,
    parameter int REP_PERIOD = c_REP_PERIOD
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    btn_step_gen_if.slave   btn_if
);

    // Reject timing values that would make a counter meaningless
    if (DEB_CYCLES < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_param
        $error("btn_step_gen: DEB_CYCLES, REP_DELAY and REP_PERIOD must be >= 1");
    end

    //--------------------------------------------------------------------------
    // Debounced button levels
    //--------------------------------------------------------------------------
    logic w_lvl_up;
    logic w_rise_up;
    logic w_lvl_dn;
    logic w_rise_dn;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_up (
        .CLK     (CLK),
        .RST     (RST),
        .i_btn   (btn_if.BTN_UP),
        .o_level (w_lvl_up),
        .o_rise  (w_rise_up)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_dn (
        .CLK     (CLK),
        .RST     (RST),
        .i_btn   (btn_if.BTN_DOWN),
        .o_level (w_lvl_dn),
        .o_rise  (w_rise_dn)
    );

    //--------------------------------------------------------------------------
    // Main FSM
    //--------------------------------------------------------------------------
    btn_state_t r_state;
    btn_state_t w_state_nxt;
    logic       r_dir;          // button owning DELAY/REPEAT: 0 = up, 1 = down
    logic       w_dir_nxt;
    logic       r_up;
    logic       r_down;
    logic       w_up_nxt;
    logic       w_down_nxt;
    logic       w_active;       // owning button still accepted-high

    assign w_active = r_dir ? w_lvl_dn : w_lvl_up;

`ifdef BTN_AUTOREPEAT_EN
    localparam int              c_DW      = cnt_width(REP_DELAY);
    localparam int              c_PW      = cnt_width(REP_PERIOD);
    localparam logic [c_DW-1:0] c_DLY_MAX = c_DW'(REP_DELAY - 1);
    localparam logic [c_PW-1:0] c_PER_MAX = c_PW'(REP_PERIOD - 1);

    logic [c_DW-1:0] r_dly_cnt;
    logic [c_DW-1:0] w_dly_cnt_nxt;
    logic [c_PW-1:0] r_per_cnt;
    logic [c_PW-1:0] w_per_cnt_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dly_cnt <= '0;
            r_per_cnt <= '0;
        end else begin
            r_dly_cnt <= w_dly_cnt_nxt;
            r_per_cnt <= w_per_cnt_nxt;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_up    <= w_up_nxt;
            r_down  <= w_down_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_up_nxt    = 1'b0;
        w_down_nxt  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        // Counters are cleared everywhere except while counting in their state
        w_dly_cnt_nxt = '0;
        w_per_cnt_nxt = '0;
`endif

        if (!btn_if.EN) begin
            // A button held while editing is disabled must be released and
            // pressed again before it can step, hence LOCKOUT.
            w_state_nxt = (w_lvl_up || w_lvl_dn) ? LOCKOUT : IDLE;
        end else if (w_lvl_up && w_lvl_dn) begin
            w_state_nxt = LOCKOUT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise_up && !w_lvl_dn) begin
                        w_up_nxt    = 1'b1;
                        w_dir_nxt   = 1'b0;
                        w_state_nxt = DELAY;
                    end else if (w_rise_dn && !w_lvl_up) begin
                        w_down_nxt  = 1'b1;
                        w_dir_nxt   = 1'b1;
                        w_state_nxt = DELAY;
                    end
                end

                DELAY: begin
                    if (!w_active) begin
                        w_state_nxt = IDLE;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (r_dly_cnt == c_DLY_MAX) begin
                        w_up_nxt    = ~r_dir;
                        w_down_nxt  = r_dir;
                        w_state_nxt = REPEAT;
                    end else begin
                        w_dly_cnt_nxt = r_dly_cnt + 1'b1;
                    end
`endif
                end

`ifdef BTN_AUTOREPEAT_EN
                REPEAT: begin
                    if (!w_active) begin
                        w_state_nxt = IDLE;
                    end else if (r_per_cnt == c_PER_MAX) begin
                        w_up_nxt   = ~r_dir;
                        w_down_nxt = r_dir;
                    end else begin
                        w_per_cnt_nxt = r_per_cnt + 1'b1;
                    end
                end
`endif

                LOCKOUT: begin
                    if (!w_lvl_up && !w_lvl_dn) begin
                        w_state_nxt = IDLE;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Strobes are registered; EN gates them so disabling edit mode
    // silences the outputs within the same cycle.
    assign btn_if.UP   = r_up   & btn_if.EN;
    assign btn_if.DOWN = r_down & btn_if.EN;

endmodule
`default_nettype wire

// File: doc/btn_step_gen.md
BTN_STEP_GEN -- requirements
Module: btn_step_gen

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, meaning consecutive stable cycles needed to accept a new button level.
REQ-002 SHALL have parameter REP_DELAY, default 50000000, meaning cycles from the first pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter REP_PERIOD, default 15000000, meaning cycles between successive auto-repeat pulses.
REQ-004 SHALL have port CLK, input, 1 bit, system clock; all logic rising-edge.
REQ-005 SHALL have port RST, input, 1 bit, reset, asynchronous, active-high.
REQ-006 SHALL have port BTN_UP, input, 1 bit, raw asynchronous increment button, active-high.
REQ-007 SHALL have port BTN_DOWN, input, 1 bit, raw asynchronous decrement button, active-high.
REQ-008 SHALL have port EN, input, 1 bit, edit-mode enable; the same signal drives Modificando of the field registers.
REQ-009 SHALL have port UP, output, 1 bit, single-cycle increment strobe to the field registers.
REQ-010 SHALL have port DOWN, output, 1 bit, single-cycle decrement strobe to the field registers.

Function
REQ-011 SHALL pass each raw button through a 2-flop synchronizer.
REQ-012 Debounce SHALL change the accepted level only after the synchronized input has differed from it for DEB_CYCLES consecutive cycles.
REQ-013 Any bounce during debounce SHALL restart the debounce count from zero.
REQ-014 The main FSM SHALL have states IDLE, DELAY, REPEAT and LOCKOUT.
REQ-015 IDLE -> DELAY: when EN=1 and exactly one accepted level rises, the block SHALL assert the matching strobe for one cycle, in the cycle after the accepted level rises.
REQ-016 Latency: from a clean raw edge to the strobe SHALL be exactly 2+DEB_CYCLES+1 cycles.
REQ-017 DELAY -> REPEAT: when the same button is still accepted-high REP_DELAY cycles after the first strobe, the block SHALL issue one strobe.
REQ-018 In REPEAT, the block SHALL issue one strobe every REP_PERIOD cycles while that button is held.
REQ-019 DELAY or REPEAT -> IDLE: when the active button's accepted level falls, the FSM SHALL return to IDLE with no strobe.
REQ-020 -> LOCKOUT: when both accepted levels are high, the FSM SHALL enter LOCKOUT from any state and emit no strobes.
REQ-021 LOCKOUT -> IDLE: only when both accepted levels are low.
REQ-022 EN=0 SHALL force UP=DOWN=0 in the same cycle.
REQ-023 While EN=0, the FSM SHALL go to LOCKOUT if any button is held, else IDLE; holding a button across an EN rise SHALL therefore not strobe until it is released and pressed again.
REQ-024 UP and DOWN SHALL never be high in the same cycle.
REQ-025 Each strobe SHALL be exactly one cycle wide.
REQ-026 Counters SHALL be sized with $clog2 of their parameter; counters SHALL saturate and never wrap.
REQ-027 Outputs SHALL be registered.

Reset
REQ-028 RST SHALL clear synchronizers, accepted levels, all counters, UP and DOWN to 0, and set the FSM to IDLE, asynchronously.
REQ-029 A button held through RST release SHALL be treated as a fresh press: one strobe after 2+DEB_CYCLES+1 cycles, if EN=1.
REQ-030 RST asserted mid-repeat SHALL drop any strobe immediately.

Configuration
REQ-031 Macro BTN_AUTOREPEAT_EN defined: REQ-017/018 apply.
REQ-032 Macro BTN_AUTOREPEAT_EN undefined: REPEAT state and repeat counters SHALL be absent; the FSM SHALL stay in DELAY until release; one strobe per press.

Structure
REQ-033 Shared package btn_pkg SHALL hold the FSM state enum and the default DEB_CYCLES, REP_DELAY and REP_PERIOD constants.
REQ-034 Synchronizer plus debounce SHALL be sub-module btn_debounce, instantiated twice.

Verification (DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=5)
REQ-035 EN=1, BTN_UP held 10 cycles -> exactly one UP pulse, 7 cycles after the raw rise; DOWN stays 0.
REQ-036 EN=1, BTN_DOWN held 60 cycles -> DOWN pulses at t=7, 27, 32, 37, ...; pulses stop within 7 cycles of release.
REQ-037 BTN_UP toggling every 2 cycles for 30 cycles, then stable high -> a single UP pulse 7 cycles after it becomes stable.
REQ-038 Both buttons pressed together, then BTN_DOWN released while BTN_UP stays held -> no pulses; a new UP pulse only after full release and re-press.
REQ-039 BTN_UP held while EN rises 0->1 -> no pulse; release and re-press -> one pulse.
REQ-040 RST pulsed mid-REPEAT -> UP=0 within the reset; button still held -> one pulse 7 cycles after RST falls.
REQ-041 Build with BTN_AUTOREPEAT_EN undefined, re-run REQ-036 -> exactly one DOWN pulse.
